data_mem_lsu: RTL
=================

Name: data_mem_lsu

Overview:
- Parametrised successor of the single-port data memory. It adds RISC-V byte/halfword/word stores with true byte enables, and sign/zero-extended loads.
- Requests use a valid/ready handshake; load responses are registered.
- Sits between the core's execute/memory stage and an on-chip word-organised RAM, and exposes an access-fault flag.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be 32 (funct3 decoding is RV32 sized).
- ADDR_WIDTH, 32, byte-address width.
- MEM_SIZE, 64, depth in words; must be a power of two and at least 2.
- INIT_ZERO, 1, 1 = every word is 0 after configuration.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_funct3  in  3  RISC-V width/sign code.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- rsp_valid  out  1  load response (or fault) valid for exactly one cycle.
- rsp_rdata  out  DATA_WIDTH  extended load data.
- rsp_fault  out  1  access fault; qualified by rsp_valid.

Behaviour:
- Reset (rst_n=0 at posedge):
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0; FSM goes to IDLE.
  - RAM contents are not cleared by reset.
- FSM states: IDLE, RESP.
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) is accepted.
    - Store: performed this posedge; FSM stays in IDLE; no response is produced.
    - Load: RAM word registered; FSM goes to RESP.
  - RESP: req_ready=0; rsp_valid=1 for one cycle; FSM returns to IDLE.
- Latency and throughput:
  - Load: response one cycle after acceptance; one load per 2 cycles.
  - Store: accepted every cycle.
- Word index = req_addr[ADDR_WIDTH-1:2] modulo MEM_SIZE; higher bits wrap silently.
- Byte offset = req_addr[1:0].
- Store funct3:
  - 000 SB: byte lane = offset; data = wdata[7:0].
  - 001 SH: lanes offset, offset+1; data = wdata[15:0].
  - 010 SW: all 4 lanes; data = wdata.
  - Other codes: no write; fault per Optional Feature.
  - Lanes not enabled keep their old value; no read-modify-write through stale data.
- Load funct3:
  - 000 LB, 100 LBU: byte at offset, sign-extended (LB) or zero-extended (LBU).
  - 001 LH, 101 LHU: halfword at offset, sign-extended (LH) or zero-extended (LHU).
  - 010 LW: whole word.
  - Other codes: rdata=0, and rsp_fault=1 for this load.
- Alignment: SH/LH/LHU require offset[0]=0; SW/LW require offset=00. Misaligned handling is per Optional Feature.
- rsp_rdata holds its last value while rsp_valid=0.
- Simultaneous events:
  - A req_valid in RESP is not accepted; the requester must hold the request.
  - A load following a store to the same word returns the newly stored data (write completes at the accept edge; the read occurs at the next accept).
- Reset mid-operation: reset in RESP drops the pending response (rsp_valid=0 at the next cycle).

Optional Feature:
- Macro: DATA_MEM_LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned store: suppressed (no lane written); produces a one-cycle fault response through RESP, so FSM goes to RESP with rsp_fault=1 and rdata=0.
  - Misaligned load: rsp_fault=1, rdata=0.
  - Illegal store funct3: also trapped this way.
- Undefined:
  - Misaligned accesses are aligned down (offset bits forced to 0 for H/W).
  - Illegal store funct3 is silently ignored.
  - Stores never produce responses.

Decomposition:
- Package data_mem_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding.
  - A function for byte-enable generation from funct3 and offset.
- Sub-module data_mem_bank holds:
  - MEM_SIZE x DATA_WIDTH RAM with 4-bit byte-enable synchronous write and registered read.
  - One instance, so the array can be swapped for a vendor RAM.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp_valid=0 throughout; then req_ready=1 the cycle after release.
- Bytes: SW 0x11223344 @0x10; SB 0xAA @0x12; LW @0x10 -> rsp_rdata=0x11AA3344 one cycle after accept.
- Extension: SW 0x80F0_7F81 @0x20; then
  - LB @0x20 -> 0xFFFFFF81
  - LBU @0x20 -> 0x00000081
  - LH @0x22 -> 0xFFFF80F0
  - LHU @0x22 -> 0x000080F0
- Wrap: SW 0xDEADBEEF @ (MEM_SIZE*4 + 4); LW @0x4 -> 0xDEADBEEF.
- Back-pressure: issue a load and a second request back-to-back -> second request is held (req_ready=0 in RESP) and accepted next cycle; responses arrive in order.
- Misalign, with macro: SH @0x31 -> rsp_valid=1, rsp_fault=1, and word 0x30 unchanged.
- Misalign, without macro: SH 0xBEEF @0x31 -> lanes 0-1 of word 0x30 written; LHU @0x30 -> 0x0000BEEF.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared definitions for the data_mem_lsu load/store unit.
//   - RISC-V funct3 width/sign codes
//   - FSM state encoding and the registered response context
//   - helpers for funct3 legality, alignment and byte-enable generation
package data_mem_pkg;

  localparam int unsigned LANES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // What the response path needs to extend the registered RAM word.
  typedef struct packed {
    logic [2:0] f3;
    logic [1:0] off;
    logic       zero;
  } rsp_ctx_t;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W};
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Offset forced down to the natural boundary of the access size.
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return {off[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return off;
    endcase
  endfunction

  // Byte enables for a store; expects an already-aligned offset.
  function automatic logic [LANES-1:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    return 4'(4'b0001 << off);
      F3_H:    return off[1] ? 4'b1100 : 4'b0011;
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if: request/response bus between the core memory stage (master)
// and data_mem_lsu (slave).
//   req_valid/req_ready  handshake; req_we, req_addr, req_funct3, req_wdata payload
//   rsp_valid            one-cycle response strobe; rsp_rdata, rsp_fault payload
interface data_mem_lsu_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_fault;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/data_mem_bank.sv
// data_mem_bank: MEM_SIZE x DATA_WIDTH single-port RAM, byte-enable synchronous
// write and registered read. Kept standalone so a vendor macro can replace it.
//   clk      clock
//   i_we     write strobe, i_be lane enables, i_wdata lane-replicated data
//   i_re     read strobe; o_rdata updates only on a read and holds otherwise
//   i_addr   word index
module data_mem_bank
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 64,
  parameter int unsigned INIT_ZERO  = 1,
  localparam int unsigned IDX_W     = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_addr,
  input  logic [LANES-1:0]      i_be,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  if ((MEM_SIZE < 2) || ((MEM_SIZE & (MEM_SIZE - 1)) != 0)) begin : g_chk_size
    $error("data_mem_bank: MEM_SIZE must be a power of two and at least 2");
  end
  // The array has no reset; its power-up image (all zero when INIT_ZERO=1)
  // belongs to the RAM configuration, not to this logic.
  if (INIT_ZERO > 1) begin : g_chk_init
    $error("data_mem_bank: INIT_ZERO must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Per-lane write leaves disabled lanes untouched; read is registered.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (i_be[l]) r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: RV32 load/store unit in front of a word-organised data RAM.
// Byte/halfword/word stores with byte enables, sign/zero-extended loads,
// valid/ready request handshake and a one-cycle registered load response.
//   clk, rst_n  clock and synchronous active-low reset
//   bus         data_mem_lsu_if.slave (request + response channels)
// Build option DATA_MEM_LSU_MISALIGN_TRAP_EN: misaligned accesses and illegal
// store funct3 raise a fault response instead of being aligned down/ignored.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 64,
  parameter int unsigned INIT_ZERO  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_lsu_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(MEM_SIZE);

  if (DATA_WIDTH != 32) begin : g_chk_dw
    $error("data_mem_lsu: DATA_WIDTH must be 32");
  end

  state_e                r_state, w_state_nxt;
  logic                  r_req_ready, w_req_ready_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic                  r_rsp_fault;
  rsp_ctx_t              r_ctx;

  logic                  w_accept;
  logic [1:0]            w_off, w_off_eff;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_st_fault, w_ld_fault, w_resp_fault, w_resp_req;
  logic [LANES-1:0]      w_be;
  logic [DATA_WIDTH-1:0] w_wdata, w_word, w_rsp_rdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_unused_addr;

  // Request decode.
  assign w_accept      = bus.req_valid & r_req_ready & rst_n;
  assign w_off         = bus.req_addr[1:0];
  assign w_idx         = bus.req_addr[IDX_W+1:2];
  assign w_unused_addr = ^bus.req_addr[ADDR_WIDTH-1:IDX_W+2];

`ifdef DATA_MEM_LSU_MISALIGN_TRAP_EN
  assign w_off_eff  = w_off;
  assign w_st_fault = is_misaligned(bus.req_funct3, w_off) | ~store_f3_legal(bus.req_funct3);
  assign w_ld_fault = is_misaligned(bus.req_funct3, w_off) | ~load_f3_legal(bus.req_funct3);
`else
  assign w_off_eff  = align_off(bus.req_funct3, w_off);
  assign w_st_fault = 1'b0;
  assign w_ld_fault = ~load_f3_legal(bus.req_funct3);
`endif

  assign w_resp_fault = bus.req_we ? w_st_fault : w_ld_fault;
  // Loads always respond; stores only when they fault.
  assign w_resp_req   = w_accept & (~bus.req_we | w_st_fault);
  // Illegal store funct3 already yields no lanes.
  assign w_be         = w_st_fault ? '0 : byte_en(bus.req_funct3, w_off_eff);

  // Store data replicated across lanes; enables pick the target lanes.
  always_comb begin
    w_wdata = bus.req_wdata;
    case (bus.req_funct3)
      F3_B:    w_wdata = {(DATA_WIDTH/8){bus.req_wdata[7:0]}};
      F3_H:    w_wdata = {(DATA_WIDTH/16){bus.req_wdata[15:0]}};
      default: w_wdata = bus.req_wdata;
    endcase
  end

  data_mem_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_SIZE   (MEM_SIZE),
    .INIT_ZERO  (INIT_ZERO)
  ) u_bank (
    .clk     (clk),
    .i_we    (w_accept & bus.req_we),
    .i_re    (w_accept & ~bus.req_we & ~w_ld_fault),
    .i_addr  (w_idx),
    .i_be    (w_be),
    .i_wdata (w_wdata),
    .o_rdata (w_word)
  );

  // Next state and registered-output values.
  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE: if (w_resp_req) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_req_ready_nxt = (w_state_nxt == ST_IDLE);
    w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_ctx       <= '{f3: 3'b000, off: 2'b00, zero: 1'b1};
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_fault <= w_rsp_valid_nxt & w_resp_fault;
      if (w_resp_req) begin
        r_ctx <= '{f3: bus.req_funct3, off: w_off_eff, zero: w_resp_fault};
      end
    end
  end

  // Extension works off registered context only, so rdata holds between loads.
  assign w_byte = w_word[{r_ctx.off, 3'b000} +: 8];
  assign w_half = w_word[{r_ctx.off[1], 4'b0000} +: 16];

  always_comb begin
    w_rsp_rdata = '0;
    case (r_ctx.f3)
      F3_B:    w_rsp_rdata = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      F3_BU:   w_rsp_rdata = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      F3_H:    w_rsp_rdata = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      F3_HU:   w_rsp_rdata = {{(DATA_WIDTH-16){1'b0}}, w_half};
      F3_W:    w_rsp_rdata = w_word;
      default: w_rsp_rdata = '0;
    endcase
    if (r_ctx.zero) w_rsp_rdata = '0;
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_fault = r_rsp_fault;
  assign bus.rsp_rdata = w_rsp_rdata;

endmodule
